bcd_scan_display: RTL and testbench



---
 rtl/bcd_scan_display.sv | 97 +++++++++
 tb/tb_bcd_scan_display.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - time-multiplexed BCD scan controller for a common-anode 7-segment display
module bcd_scan_display #(
  parameter  int NUM_DIGITS  = 4,
  parameter  int REFRESH_DIV = 50000,
  localparam int IDX_W       = $clog2(NUM_DIGITS),
  localparam int PW          = $clog2(REFRESH_DIV)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      load,
  input  logic                      blank_lz,
  output logic [3:0]                bcd_out,
  output logic [NUM_DIGITS-1:0]     an_n,
  output logic                      dp_out,
  output logic [IDX_W-1:0]          digit_idx
);

  logic [PW-1:0]           presc;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] cap_digits;
  logic [NUM_DIGITS-1:0]   cap_dp;

  logic [NUM_DIGITS-1:0]   blank_vec;
  logic                    above_zero;
  logic [3:0]              d;
  logic [3:0]              cur_digit;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   next_an;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PW'(REFRESH_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_digits <= '0;
      cap_dp     <= '0;
    end else if (load) begin
      cap_digits <= digits_in;
      cap_dp     <= dp_in;
    end
  end

  // Walk from the MSD down so each digit knows whether everything above it is zero.
  always_comb begin
    blank_vec  = '0;
    above_zero = 1'b1;
    d          = 4'd0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      d            = cap_digits[4*i +: 4];
      blank_vec[i] = (d > 4'd9) || (blank_lz && (i != 0) && (d == 4'd0) && above_zero);
      above_zero   = above_zero && (d == 4'd0);
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    next_an   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_digit = cap_digits[4*i +: 4];
        cur_dp    = cap_dp[i];
        cur_blank = blank_vec[i];
        next_an[i] = blank_vec[i];
      end
    end
  end

  // Enable, data and dp share one register stage so they never skew.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_out   <= 4'd0;
      an_n      <= '1;
      dp_out    <= 1'b0;
      digit_idx <= '0;
    end else begin
      bcd_out   <= cur_blank ? 4'd0 : cur_digit;
      an_n      <= next_an;
      dp_out    <= cur_dp && !cur_blank;
      digit_idx <= idx;
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - directed self-checking bench for bcd_scan_display
module tb_bcd_scan_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [3:0]  bcd_out;
  logic [3:0]  an_n;
  logic        dp_out;
  logic [1:0]  digit_idx;

  int checks   = 0;
  int failures = 0;
  int edges;

  bcd_scan_display #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digits_in (digits_in),
    .dp_in     (dp_in),
    .load      (load),
    .blank_lz  (blank_lz),
    .bcd_out   (bcd_out),
    .an_n      (an_n),
    .dp_out    (dp_out),
    .digit_idx (digit_idx)
  );

  always #5 clk = ~clk;

  // Edges since reset release; output after edge n shows slot ((n-1)/4)%4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    @(negedge clk);
    digits_in = d;
    dp_in     = p;
    load      = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; load = 1'b0; digits_in = 16'h0; dp_in = 4'h0; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (an_n !== 4'b1111) begin failures++; $display("FAIL reset_an got=%b exp=1111", an_n); end
    checks++;
    if (bcd_out !== 4'd0 || dp_out !== 1'b0 || digit_idx !== 2'd0) begin
      failures++; $display("FAIL reset_data got bcd=%0d dp=%b idx=%0d exp 0/0/0", bcd_out, dp_out, digit_idx);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (an_n !== 4'b1111) begin failures++; $display("FAIL release_no_edge got=%b exp=1111", an_n); end
    @(posedge clk); #1;
    checks++;
    if (an_n !== 4'b1110 || digit_idx !== 2'd0) begin
      failures++; $display("FAIL first_slot got an=%b idx=%0d exp an=1110 idx=0", an_n, digit_idx);
    end
  endtask

  task automatic test_idle_scan;
    int s;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      s = ((edges - 1) / 4) % 4;
      checks++;
      if (an_n !== ~(4'b0001 << s) || bcd_out !== 4'd0 || dp_out !== 1'b0 || digit_idx !== 2'(s)) begin
        failures++;
        $display("FAIL idle_scan k=%0d got an=%b bcd=%0d dp=%b idx=%0d exp an=%b bcd=0 dp=0 idx=%0d",
                 k, an_n, bcd_out, dp_out, digit_idx, ~(4'b0001 << s), s);
      end
    end
  endtask

  task automatic test_digits_1234;
    logic [3:0] eb[4];
    logic       ed[4];
    int s;
    eb[0] = 4'd4; eb[1] = 4'd3; eb[2] = 4'd2; eb[3] = 4'd1;
    ed[0] = 1'b0; ed[1] = 1'b1; ed[2] = 1'b0; ed[3] = 1'b0;
    blank_lz = 1'b0;
    do_load(16'h1234, 4'b0010);
    digits_in = 16'hFFFF;
    dp_in     = 4'hF;
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      s = ((edges - 1) / 4) % 4;
      checks++;
      if (an_n !== ~(4'b0001 << s) || bcd_out !== eb[s] || dp_out !== ed[s] || digit_idx !== 2'(s)) begin
        failures++;
        $display("FAIL digits_1234 slot=%0d got an=%b bcd=%0d dp=%b exp an=%b bcd=%0d dp=%b",
                 s, an_n, bcd_out, dp_out, ~(4'b0001 << s), eb[s], ed[s]);
      end
    end
  endtask

  task automatic test_leading_zero;
    logic [3:0] ea[4];
    logic [3:0] eb[4];
    logic       ed[4];
    int s;
    ea[0] = 4'b1110; ea[1] = 4'b1101; ea[2] = 4'b1111; ea[3] = 4'b1111;
    eb[0] = 4'd0;    eb[1] = 4'd5;    eb[2] = 4'd0;    eb[3] = 4'd0;
    ed[0] = 1'b0;    ed[1] = 1'b0;    ed[2] = 1'b0;    ed[3] = 1'b0;
    blank_lz = 1'b1;
    do_load(16'h0050, 4'b0100);
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      s = ((edges - 1) / 4) % 4;
      checks++;
      if (an_n !== ea[s] || bcd_out !== eb[s] || dp_out !== ed[s] || digit_idx !== 2'(s)) begin
        failures++;
        $display("FAIL lz_on slot=%0d got an=%b bcd=%0d dp=%b exp an=%b bcd=%0d dp=%b",
                 s, an_n, bcd_out, dp_out, ea[s], eb[s], ed[s]);
      end
    end
    blank_lz = 1'b0;
    ea[2] = 4'b1011; ea[3] = 4'b0111;
    ed[2] = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      s = ((edges - 1) / 4) % 4;
      checks++;
      if (an_n !== ea[s] || bcd_out !== eb[s] || dp_out !== ed[s]) begin
        failures++;
        $display("FAIL lz_off slot=%0d got an=%b bcd=%0d dp=%b exp an=%b bcd=%0d dp=%b",
                 s, an_n, bcd_out, dp_out, ea[s], eb[s], ed[s]);
      end
    end
  endtask

  task automatic test_invalid_code;
    logic [3:0] ea[4];
    logic [3:0] eb[4];
    int s;
    ea[0] = 4'b1110; ea[1] = 4'b1111; ea[2] = 4'b1011; ea[3] = 4'b0111;
    eb[0] = 4'd7;    eb[1] = 4'd0;    eb[2] = 4'd0;    eb[3] = 4'd0;
    blank_lz = 1'b0;
    do_load(16'h00A7, 4'b0010);
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      s = ((edges - 1) / 4) % 4;
      checks++;
      if (an_n !== ea[s] || bcd_out !== eb[s] || dp_out !== 1'b0) begin
        failures++;
        $display("FAIL invalid_code slot=%0d got an=%b bcd=%0d dp=%b exp an=%b bcd=%0d dp=0",
                 s, an_n, bcd_out, dp_out, ea[s], eb[s]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic found;
    int   ns;
    found = 1'b0;
    for (int t = 0; t < 8 && !found; t++) begin
      @(negedge clk);
      if (edges % 4 == 3) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL advance_align got=none exp=aligned_edge"); end
    digits_in = 16'h9999;
    dp_in     = 4'h0;
    load      = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    ns = (edges / 4) % 4;
    @(posedge clk); #1;
    checks++;
    if (an_n !== ~(4'b0001 << ns) || bcd_out !== 4'd9 || digit_idx !== 2'(ns)) begin
      failures++;
      $display("FAIL load_on_advance got an=%b bcd=%0d idx=%0d exp an=%b bcd=9 idx=%0d",
               an_n, bcd_out, digit_idx, ~(4'b0001 << ns), ns);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (an_n !== 4'b1111 || bcd_out !== 4'd0 || dp_out !== 1'b0 || digit_idx !== 2'd0) begin
      failures++;
      $display("FAIL async_reset got an=%b bcd=%0d dp=%b idx=%0d exp an=1111 bcd=0 dp=0 idx=0",
               an_n, bcd_out, dp_out, digit_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (an_n !== 4'b1110 || bcd_out !== 4'd0 || digit_idx !== 2'd0) begin
      failures++;
      $display("FAIL restart_slot0 got an=%b bcd=%0d idx=%0d exp an=1110 bcd=0 idx=0",
               an_n, bcd_out, digit_idx);
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_digits_1234();
    test_leading_zero();
    test_invalid_code();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
